// File: rtl/step_counter.sv
// Run-gated step counter: up/down by a runtime step within 0..limit,
// wrapping or saturating at the boundary, with load, tc pulse and sticky ovf.
module step_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             up,
  input  logic             sat,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clr,
  output logic [WIDTH-1:0] state,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH:0]   sum;
  logic             over;
  logic [WIDTH-1:0] nxt;
  logic             evt;
  logic             hit;

  assign sum  = {1'b0, state} + {1'b0, step};
  assign over = state > limit;
  assign hit  = run & ~load & evt;

  always_comb begin
    nxt = state;
    evt = 1'b0;
    if (up) begin
      // a state loaded above limit is a boundary event even with step = 0
      if (over || sum > {1'b0, limit}) begin
        evt = 1'b1;
        nxt = sat ? limit : '0;
      end else begin
        nxt = sum[WIDTH-1:0];
      end
    end else begin
      if (over) begin
        evt = 1'b1;
        nxt = limit;
      end else if (state >= step) begin
        nxt = state - step;
      end else begin
        evt = 1'b1;
        nxt = sat ? '0 : limit;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (load) begin
        state <= load_value;
        tc    <= 1'b0;
      end else if (run) begin
        state <= nxt;
        tc    <= evt;
      end else begin
        tc    <= 1'b0;
      end
      ovf <= hit | (ovf & ~clr);
    end
  end

endmodule

// File: tb/tb_step_counter.sv
// Directed bench for step_counter with hand-computed expected values.
module tb_step_counter;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         run, up, sat, load, clr;
  logic [W-1:0] step, limit, load_value;
  logic [W-1:0] state;
  logic         tc, ovf;

  int n_cmp = 0;
  int n_bad = 0;

  step_counter #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .up         (up),
    .sat        (sat),
    .step       (step),
    .limit      (limit),
    .load       (load),
    .load_value (load_value),
    .clr        (clr),
    .state      (state),
    .tc         (tc),
    .ovf        (ovf)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic tick_chk(input string tag, input int s, input int t);
    tick();
    chk({tag, ".state"}, int'(state), s);
    chk({tag, ".tc"}, int'(tc), t);
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; up = 1'b1; sat = 1'b0;
    load = 1'b0; clr = 1'b0; step = '0; limit = '0;
    load_value = '0;
    #3;
    chk("rst.state", int'(state), 0);
    chk("rst.tc", int'(tc), 0);
    chk("rst.ovf", int'(ovf), 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    step = 4'd2; limit = 4'd14; up = 1'b1; sat = 1'b0; run = 1'b1;

    // legacy count-by-two wrap
    for (int i = 1; i <= 8; i++)
      tick_chk("legacy", (2 * i) % 16, (i == 8) ? 1 : 0);
    chk("legacy.ovf", int'(ovf), 1);

    // pause / resume
    tick_chk("cnt", 2, 0);
    tick_chk("cnt", 4, 0);
    tick_chk("cnt", 6, 0);
    run = 1'b0;
    tick_chk("pause", 6, 0);
    tick_chk("pause", 6, 0);

    // async reset between edges
    #3;
    reset = 1'b0;
    #1;
    chk("arst.state", int'(state), 0);
    chk("arst.tc", int'(tc), 0);
    chk("arst.ovf", int'(ovf), 0);
    reset = 1'b1;
    run = 1'b1;
    tick_chk("resume", 2, 0);
    tick_chk("resume", 4, 0);

    // saturate up then down
    load = 1'b1; load_value = 4'd0;
    tick_chk("ld0", 0, 0);
    load = 1'b0;
    sat = 1'b1; up = 1'b1; step = 4'd3; limit = 4'd10;
    tick_chk("satup", 3, 0);
    tick_chk("satup", 6, 0);
    tick_chk("satup", 9, 0);
    tick_chk("satup", 10, 1);
    tick_chk("satup", 10, 1);
    up = 1'b0; step = 4'd4;
    tick_chk("satdn", 6, 0);
    tick_chk("satdn", 2, 0);
    tick_chk("satdn", 0, 1);
    tick_chk("satdn", 0, 1);

    // down wrap
    sat = 1'b0; up = 1'b0; step = 4'd3; limit = 4'd10;
    load = 1'b1; load_value = 4'd4;
    tick_chk("dnld", 4, 0);
    load = 1'b0;
    tick_chk("dnwrap", 1, 0);
    tick_chk("dnwrap", 10, 1);
    tick_chk("dnwrap", 7, 0);

    // load priority and out-of-range clamp
    load = 1'b1; run = 1'b1; load_value = 4'd13;
    tick_chk("ldpri", 13, 0);
    load = 1'b0; up = 1'b1; sat = 1'b0;
    tick_chk("clampup", 0, 1);
    load = 1'b1;
    tick_chk("reld", 13, 0);
    load = 1'b0; up = 1'b0;
    tick_chk("clampdn", 10, 1);

    // ovf clear, set, set+clr
    run = 1'b0; clr = 1'b1;
    tick();
    chk("clr.ovf", int'(ovf), 0);
    clr = 1'b0; run = 1'b1; up = 1'b1; step = 4'd3;
    tick_chk("wrap", 0, 1);
    chk("wrap.ovf", int'(ovf), 1);
    run = 1'b0; clr = 1'b1;
    tick();
    chk("clr2.ovf", int'(ovf), 0);
    clr = 1'b0; load = 1'b1; load_value = 4'd9;
    tick_chk("ld9", 9, 0);
    chk("ld9.ovf", int'(ovf), 0);
    load = 1'b0; clr = 1'b1; run = 1'b1;
    tick_chk("setclr", 0, 1);
    chk("setclr.ovf", int'(ovf), 1);
    clr = 1'b0;

    // zero step
    step = 4'd0;
    tick_chk("step0", 0, 0);
    tick_chk("step0", 0, 0);
    load = 1'b1; load_value = 4'd5;
    tick_chk("ld5", 5, 0);
    load = 1'b0; up = 1'b0;
    tick_chk("step0dn", 5, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
